// File: rtl/qa_qlp_responder.sv
// Bring-up model of the QLP end of a CCI link: a line-granular store with in-order, fixed-latency
// read/write responses. Define QA_RSP_RANDOM_LATENCY_EN to add 0..7 cycles of LFSR jitter per request.
module qa_qlp_responder #(
  parameter int CCI_DATA_WIDTH   = 512,
  parameter int CCI_RX_HDR_WIDTH = 18,
  parameter int CCI_TX_HDR_WIDTH = 61,
  parameter int MEM_LINES        = 1024,
  parameter int FIFO_DEPTH       = 16,
  parameter int ALMFULL_SLACK    = 4,
  parameter int RSP_LATENCY      = 8
) (
  input  logic                        clk,
  input  logic                        resetb,
  input  logic [CCI_TX_HDR_WIDTH-1:0] C0TxHdr,
  input  logic                        C0TxRdValid,
  output logic                        C0TxAlmFull,
  input  logic [CCI_TX_HDR_WIDTH-1:0] C1TxHdr,
  input  logic [CCI_DATA_WIDTH-1:0]   C1TxData,
  input  logic                        C1TxWrValid,
  input  logic                        C1TxIrValid,
  output logic                        C1TxAlmFull,
  output logic [CCI_RX_HDR_WIDTH-1:0] C0RxHdr,
  output logic [CCI_DATA_WIDTH-1:0]   C0RxData,
  output logic                        C0RxRdValid,
  output logic                        C0RxWrValid,
  output logic                        C0RxCgValid,
  output logic                        C0RxUgValid,
  output logic                        C0RxIrValid,
  output logic [CCI_RX_HDR_WIDTH-1:0] C1RxHdr,
  output logic                        C1RxWrValid,
  output logic                        C1RxIrValid,
  output logic                        err_overflow
);
  localparam int AW = $clog2(MEM_LINES);
  localparam int QW = $clog2(FIFO_DEPTH);
  localparam int CW = QW + 1;
  localparam int MW = 14;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ALM_TH  = CW'(FIFO_DEPTH - ALMFULL_SLACK);
  localparam logic [15:0]   LAT_C   = 16'(RSP_LATENCY);
  localparam logic [3:0]    RSP_RD  = 4'h4;
  localparam logic [3:0]    RSP_WR  = 4'h1;

  function automatic logic due(input logic [15:0] cur, input logic [15:0] stamp,
                               input logic [15:0] thr);
    logic [15:0] age;
    age = cur - stamp;
    return age >= thr;
  endfunction

  logic [15:0]   now;
  logic [CW-1:0] wr0, rd0, wr1, rd1, occ0, occ1;
  logic [QW-1:0] h0, h1, t0, t1;
  logic          push0, push1, drop0, drop1, pop0, pop1;
  logic [15:0]   thr0, thr1;

  logic [AW-1:0]             q0_addr  [FIFO_DEPTH];
  logic [MW-1:0]             q0_mdata [FIFO_DEPTH];
  logic [15:0]               q0_stamp [FIFO_DEPTH];
  logic [AW-1:0]             q1_addr  [FIFO_DEPTH];
  logic [MW-1:0]             q1_mdata [FIFO_DEPTH];
  logic [CCI_DATA_WIDTH-1:0] q1_data  [FIFO_DEPTH];
  logic [15:0]               q1_stamp [FIFO_DEPTH];
  logic [CCI_DATA_WIDTH-1:0] store    [MEM_LINES];

  assign occ0 = wr0 - rd0;
  assign occ1 = wr1 - rd1;
  assign h0   = rd0[QW-1:0];
  assign h1   = rd1[QW-1:0];
  assign t0   = wr0[QW-1:0];
  assign t1   = wr1[QW-1:0];

  assign push0 = C0TxRdValid && (occ0 != DEPTH_C);
  assign drop0 = C0TxRdValid && (occ0 == DEPTH_C);
  assign push1 = C1TxWrValid && (occ1 != DEPTH_C);
  assign drop1 = C1TxWrValid && (occ1 == DEPTH_C);

`ifdef QA_RSP_RANDOM_LATENCY_EN
  logic [15:0] lfsr;
  logic [2:0]  q0_xd [FIFO_DEPTH];
  logic [2:0]  q1_xd [FIFO_DEPTH];

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) lfsr <= 16'hACE1;
    else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  always_ff @(posedge clk) begin
    if (push0) q0_xd[t0] <= lfsr[2:0];
    if (push1) q1_xd[t1] <= lfsr[2:0];
  end

  assign thr0 = LAT_C + 16'(q0_xd[h0]);
  assign thr1 = LAT_C + 16'(q1_xd[h1]);
`else
  assign thr0 = LAT_C;
  assign thr1 = LAT_C;
`endif

  // Only the head may leave, which keeps each channel strictly in order.
  assign pop0 = (occ0 != '0) && due(now, q0_stamp[h0], thr0);
  assign pop1 = (occ1 != '0) && due(now, q1_stamp[h1], thr1);

  // Control and response stage; store reads here see the line before this cycle's write pop.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      now          <= '0;
      wr0          <= '0;
      rd0          <= '0;
      wr1          <= '0;
      rd1          <= '0;
      C0TxAlmFull  <= 1'b0;
      C1TxAlmFull  <= 1'b0;
      err_overflow <= 1'b0;
      C0RxRdValid  <= 1'b0;
      C0RxHdr      <= '0;
      C0RxData     <= '0;
      C1RxWrValid  <= 1'b0;
      C1RxHdr      <= '0;
    end else begin
      now <= now + 16'd1;
      if (push0) wr0 <= wr0 + CW'(1);
      if (pop0)  rd0 <= rd0 + CW'(1);
      if (push1) wr1 <= wr1 + CW'(1);
      if (pop1)  rd1 <= rd1 + CW'(1);
      C0TxAlmFull  <= (occ0 >= ALM_TH);
      C1TxAlmFull  <= (occ1 >= ALM_TH);
      err_overflow <= err_overflow | drop0 | drop1;
      C0RxRdValid  <= pop0;
      C0RxHdr      <= pop0 ? CCI_RX_HDR_WIDTH'({RSP_RD, q0_mdata[h0]}) : '0;
      C0RxData     <= pop0 ? store[q0_addr[h0]] : '0;
      C1RxWrValid  <= pop1;
      C1RxHdr      <= pop1 ? CCI_RX_HDR_WIDTH'({RSP_WR, q1_mdata[h1]}) : '0;
    end
  end

  // Queue payloads and the store carry no reset; the store survives resetb.
  always_ff @(posedge clk) begin
    if (push0) begin
      q0_addr[t0]  <= C0TxHdr[14 +: AW];
      q0_mdata[t0] <= C0TxHdr[MW-1:0];
      q0_stamp[t0] <= now;
    end
    if (push1) begin
      q1_addr[t1]  <= C1TxHdr[14 +: AW];
      q1_mdata[t1] <= C1TxHdr[MW-1:0];
      q1_data[t1]  <= C1TxData;
      q1_stamp[t1] <= now;
    end
    if (pop1) store[q1_addr[h1]] <= q1_data[h1];
  end

  assign C0RxWrValid = 1'b0;
  assign C0RxCgValid = 1'b0;
  assign C0RxUgValid = 1'b0;
  assign C0RxIrValid = 1'b0;
  assign C1RxIrValid = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{C1TxIrValid, C0TxHdr[CCI_TX_HDR_WIDTH-1:14+AW],
                       C1TxHdr[CCI_TX_HDR_WIDTH-1:14+AW]};
endmodule

// File: tb/tb_qa_qlp_responder.sv
// Bench for qa_qlp_responder: table-driven requests with a per-channel scoreboard of expected
// headers, data and response cycles, plus hand sequences for flow control, overflow and reset.
module tb_qa_qlp_responder;
  localparam int DW    = 512;
  localparam int DEPTH = 16;
  // Long enough that a 17-request burst piles up before the first pop.
  localparam int LAT   = 20;
  localparam int NV    = 13;

  logic          clk, resetb;
  logic [60:0]   C0TxHdr, C1TxHdr;
  logic          C0TxRdValid, C1TxWrValid, C1TxIrValid;
  logic [DW-1:0] C1TxData;
  logic          C0TxAlmFull, C1TxAlmFull;
  logic [17:0]   C0RxHdr, C1RxHdr;
  logic [DW-1:0] C0RxData;
  logic          C0RxRdValid, C0RxWrValid, C0RxCgValid, C0RxUgValid, C0RxIrValid;
  logic          C1RxWrValid, C1RxIrValid, err_overflow;

  qa_qlp_responder #(
    .CCI_DATA_WIDTH(DW), .CCI_RX_HDR_WIDTH(18), .CCI_TX_HDR_WIDTH(61), .MEM_LINES(1024),
    .FIFO_DEPTH(DEPTH), .ALMFULL_SLACK(4), .RSP_LATENCY(LAT)
  ) dut (
    .clk(clk), .resetb(resetb),
    .C0TxHdr(C0TxHdr), .C0TxRdValid(C0TxRdValid), .C0TxAlmFull(C0TxAlmFull),
    .C1TxHdr(C1TxHdr), .C1TxData(C1TxData), .C1TxWrValid(C1TxWrValid),
    .C1TxIrValid(C1TxIrValid), .C1TxAlmFull(C1TxAlmFull),
    .C0RxHdr(C0RxHdr), .C0RxData(C0RxData), .C0RxRdValid(C0RxRdValid),
    .C0RxWrValid(C0RxWrValid), .C0RxCgValid(C0RxCgValid), .C0RxUgValid(C0RxUgValid),
    .C0RxIrValid(C0RxIrValid), .C1RxHdr(C1RxHdr), .C1RxWrValid(C1RxWrValid),
    .C1RxIrValid(C1RxIrValid), .err_overflow(err_overflow)
  );

  typedef struct {
    logic [13:0]   md;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  typedef struct {
    bit            rd;
    logic [31:0]   ra;
    logic [13:0]   rm;
    logic [DW-1:0] rexp;
    bit            wr;
    logic [31:0]   wa;
    logic [13:0]   wm;
    logic [DW-1:0] wd;
    int            gap;
  } vec_t;

  exp_t rdq[$];
  exp_t wrq[$];
  int   last_rd = 0, last_wr = 0, cyc = 0, n_chk = 0, n_fail = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [60:0] mk_hdr(input logic [31:0] a, input logic [13:0] m);
    logic [60:0] h;
    h = '0;
    h[55:52] = 4'hA;
    h[45:14] = a;
    h[13:0]  = m;
    return h;
  endfunction

  function automatic logic [DW-1:0] line_pat(input int k);
    logic [7:0] b;
    b = 8'(8'h11 * k);
    return {64{b}};
  endfunction

  function automatic vec_t mkv(input bit rd, input logic [31:0] ra, input logic [13:0] rm,
                               input logic [DW-1:0] rexp, input bit wr, input logic [31:0] wa,
                               input logic [13:0] wm, input logic [DW-1:0] wd, input int gap);
    vec_t v;
    v.rd = rd; v.ra = ra; v.rm = rm; v.rexp = rexp;
    v.wr = wr; v.wa = wa; v.wm = wm; v.wd = wd; v.gap = gap;
    return v;
  endfunction

  // Drives one cycle of requests; expected responses are queued only when keep is set.
  task automatic drive(input bit rd, input logic [31:0] ra, input logic [13:0] rm,
                       input logic [DW-1:0] rexp, input bit wr, input logic [31:0] wa,
                       input logic [13:0] wm, input logic [DW-1:0] wd, input bit keep,
                       output int t);
    exp_t e;
    @(negedge clk);
    t = cyc + 1;
    C0TxRdValid = rd;
    C0TxHdr     = mk_hdr(ra, rm);
    C1TxWrValid = wr;
    C1TxHdr     = mk_hdr(wa, wm);
    C1TxData    = wd;
    if (keep && rd) begin
      e.md = rm; e.data = rexp;
      e.cyc = (t + LAT > last_rd + 1) ? t + LAT : last_rd + 1;
      last_rd = e.cyc;
      rdq.push_back(e);
    end
    if (keep && wr) begin
      e.md = wm; e.data = wd;
      e.cyc = (t + LAT > last_wr + 1) ? t + LAT : last_wr + 1;
      last_wr = e.cyc;
      wrq.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      C0TxRdValid = 1'b0;
      C1TxWrValid = 1'b0;
      C1TxIrValid = 1'b0;
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rdvalid"}, C0RxRdValid, 0);
    chk({tag, "_wrvalid"}, C1RxWrValid, 0);
    chk({tag, "_rdhdr"}, C0RxHdr, 0);
    chk({tag, "_wrhdr"}, C1RxHdr, 0);
    chk({tag, "_rddata"}, C0RxData, 0);
    chk({tag, "_almfull"}, {C0TxAlmFull, C1TxAlmFull}, 0);
    chk({tag, "_ovf"}, err_overflow, 0);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (C0RxRdValid) begin
      chk("rd_expected", 32'(rdq.size() != 0), 1);
      if (rdq.size() != 0) begin
        e = rdq.pop_front();
        chk("rd_hdr", C0RxHdr, {4'h4, e.md});
        chk("rd_data", C0RxData, e.data);
        chk("rd_cycle", cyc, e.cyc);
      end
    end
    if (C1RxWrValid) begin
      chk("wr_expected", 32'(wrq.size() != 0), 1);
      if (wrq.size() != 0) begin
        e = wrq.pop_front();
        chk("wr_hdr", C1RxHdr, {4'h1, e.md});
        chk("wr_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    vec_t v[NV];
    int   t, t0, guard;

    v[0] = mkv(0, 0, 0, '0, 1, 32'h10, 14'h123, {64{8'hA5}}, LAT + 2);
    v[1] = mkv(1, 32'h10, 14'h55, {64{8'hA5}}, 0, 0, 0, '0, LAT + 2);
    for (int k = 1; k <= 4; k++) begin
      v[1 + k] = mkv(0, 0, 0, '0, 1, 32'(k), 14'(512 + k), line_pat(k), (k == 4) ? LAT + 2 : 0);
      v[5 + k] = mkv(1, 32'(k), 14'(k), line_pat(k), 0, 0, 0, '0, (k == 4) ? LAT + 2 : 0);
    end
    v[10] = mkv(0, 0, 0, '0, 1, 32'h410, 14'h3FFF, {64{8'h3C}}, LAT + 2);
    v[11] = mkv(1, 32'h10, 14'h3FFF, {64{8'h3C}}, 1, 32'h5, 14'h7, {64{8'h77}}, LAT + 2);
    v[12] = mkv(0, 0, 0, '0, 1, 32'h20, 14'h20, '0, LAT + 2);

    C0TxRdValid = 1'b0; C1TxWrValid = 1'b0; C1TxIrValid = 1'b0;
    C0TxHdr = '0; C1TxHdr = '0; C1TxData = '0;
    resetb = 1'b1;
    #2 resetb = 1'b0;

    // Requests presented during reset must vanish.
    drive(1, 32'h1, 14'h1, '0, 1, 32'h1, 14'h2, {64{8'hEE}}, 1'b0, t);
    idle(2);
    chk_quiet("reset");
    chk("tied_zero", {C0RxWrValid, C0RxCgValid, C0RxUgValid, C0RxIrValid, C1RxIrValid}, 0);
    resetb = 1'b1;
    idle(LAT + 4);

    for (int i = 0; i < NV; i++) begin
      drive(v[i].rd, v[i].ra, v[i].rm, v[i].rexp, v[i].wr, v[i].wa, v[i].wm, v[i].wd, 1'b1, t);
      if (v[i].gap > 0) idle(v[i].gap);
    end

    // Read and write of the same line popping together: read sees the old line.
    drive(1, 32'h20, 14'h21, 512'h0, 1, 32'h20, 14'h22, 512'hFF, 1'b1, t);
    idle(LAT + 2);
    drive(1, 32'h20, 14'h23, 512'hFF, 0, 0, 0, '0, 1'b1, t);
    idle(LAT + 2);

    // Burst of 17 reads into a 16-deep queue.
    t0 = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(1, 32'(1 + i % 4), 14'(256 + i), line_pat(1 + i % 4), 0, 0, 0, '0, i < DEPTH, t);
      C1TxIrValid = (i == 5);
      if (i == 0) t0 = t;
      if (i == 12) chk("alm0_at_threshold", C0TxAlmFull, 0);
      if (i == 13) begin
        chk("alm0_rise", C0TxAlmFull, 1);
        chk("alm1_quiet", C1TxAlmFull, 0);
      end
      if (i == DEPTH) chk("ovf_before_drop", err_overflow, 0);
    end
    idle(1);
    chk("ovf_set", err_overflow, 1);
    guard = 0;
    while (cyc < t0 + LAT + 4 && guard < 100) begin
      idle(1);
      guard++;
    end
    chk("alm0_hold_at_12", C0TxAlmFull, 1);
    idle(1);
    chk("alm0_fall", C0TxAlmFull, 0);
    idle(LAT);
    chk("ovf_sticky", err_overflow, 1);

    // Reset in the middle of three outstanding reads.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'(1 + i), 14'(48 + i), line_pat(1 + i), 0, 0, 0, '0, 1'b1, t);
      if (i == 0) t0 = t;
    end
    idle(1);
    guard = 0;
    while (cyc < t0 + LAT && guard < 100) begin
      idle(1);
      guard++;
    end
    chk("rd_valid_before_reset", C0RxRdValid, 1);
    #1 resetb = 1'b0;
    #1;
    chk_quiet("midreset");
    rdq.delete();
    wrq.delete();
    last_rd = 0;
    last_wr = 0;
    idle(2);
    resetb = 1'b1;
    idle(LAT + 5);
    drive(1, 32'h10, 14'h3E, {64{8'h3C}}, 0, 0, 0, '0, 1'b1, t);
    idle(LAT + 5);

    chk("rdq_drained", rdq.size(), 0);
    chk("wrq_drained", wrq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/qa_qlp_responder.md
Name: qa_qlp_responder

Overview:
- Simulation/bring-up model of the platform (QLP) end of the CCI link; connects to the same wires an AFU drives.
- Accepts AFU read requests on channel 0 and write requests on channel 1 and keeps a small line-granular backing store.
- Returns read and write responses in order, after a programmable latency, with almost-full flow control.
- Lets shims and AFUs be exercised without the real platform.

Parameters:
- CCI_DATA_WIDTH, 512, line width in bits
- CCI_RX_HDR_WIDTH, 18, Rx header width
- CCI_TX_HDR_WIDTH, 61, Tx header width
- MEM_LINES, 1024, backing-store depth in lines (power of 2)
- FIFO_DEPTH, 16, request queue depth per channel (power of 2)
- ALMFULL_SLACK, 4, free entries remaining when almost-full asserts
- RSP_LATENCY, 8, minimum request-to-response cycles (2..32767)

Ports:
- clk  input  1  clock
- resetb  input  1  asynchronous active-low reset
- C0TxHdr  input  CCI_TX_HDR_WIDTH  read request header
- C0TxRdValid  input  1  read request valid
- C0TxAlmFull  output  1  channel-0 flow control
- C1TxHdr  input  CCI_TX_HDR_WIDTH  write request header
- C1TxData  input  CCI_DATA_WIDTH  write data
- C1TxWrValid  input  1  write request valid
- C1TxIrValid  input  1  interrupt request (accepted, no response)
- C1TxAlmFull  output  1  channel-1 flow control
- C0RxHdr  output  CCI_RX_HDR_WIDTH  read response header
- C0RxData  output  CCI_DATA_WIDTH  read data
- C0RxRdValid  output  1  read response valid
- C0RxWrValid, C0RxCgValid, C0RxUgValid, C0RxIrValid  output  1 each  tied 0
- C1RxHdr  output  CCI_RX_HDR_WIDTH  write response header
- C1RxWrValid  output  1  write response valid
- C1RxIrValid  output  1  tied 0
- err_overflow  output  1  sticky: request arrived with its queue full

Behaviour:
- Tx header fields: [55:52] request type, [45:14] line address, [13:0] mdata. Rx header fields: [17:14] response type, [13:0] mdata.
- Response types: read = 4'h4, write = 4'h1. Request type field is ignored; the channel determines read vs write.
- Store index: address[log2(MEM_LINES)-1:0]. Upper address bits are ignored, so addresses alias modulo MEM_LINES.
- A 16-bit free-running cycle counter stamps each accepted request.
- Queue entries: channel 0 holds {addr, mdata, stamp}; channel 1 holds {addr, mdata, data, stamp}.
- Head of a queue is eligible when (now - stamp) mod 2^16 >= RSP_LATENCY.
- Each channel pops at most one eligible head per cycle and drives valid for exactly that one cycle.
- Read pop: C0RxData = store[addr], C0RxHdr = {4'h4, mdata}.
- Write pop: store[addr] <= data, C1RxHdr = {4'h1, mdata}.
- Latency: a request sampled at edge t into an empty queue produces a response valid in the cycle following edge t+RSP_LATENCY.
- Responses are strictly in order per channel. There is no ordering guarantee between channels.
- Read and write pop of the same line in the same cycle: the read returns the pre-write (old) data.
- AlmFull = occupancy >= FIFO_DEPTH-ALMFULL_SLACK, registered, so it rises one cycle after the threshold is reached.
- Simultaneous push and pop leave occupancy unchanged.
- Request arriving while its queue is full: the request is dropped and err_overflow is set. err_overflow clears only on reset.
- C1TxIrValid is ignored beyond being accepted.
- Reset (asynchronous, any time, including mid-operation):
  - all queues are flushed and the counter is zeroed;
  - all valids, headers, data, AlmFull and err_overflow go to 0;
  - store contents are preserved (store is not reset).
- Requests presented while resetb=0 are ignored.

Optional Feature:
- Macro: QA_RSP_RANDOM_LATENCY_EN.
- Defined:
  - a 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) advances every cycle;
  - each accepted request adds an extra delay of lfsr[2:0] (0..7 cycles) to its eligibility threshold, stored per entry;
  - responses remain in order per channel, so a later entry waits for its predecessor.
- Undefined: the LFSR is absent and latency is exactly RSP_LATENCY.

Test Plan:
- Write addr 0x10, data 512'hA5..A5, mdata 0x123; after C1RxWrValid, read addr 0x10, mdata 0x55 -> C1RxHdr = {4'h1,14'h123} 9 cycles after the write (RSP_LATENCY=8); C0RxHdr = {4'h4,14'h55}, C0RxData = A5..A5.
- Four back-to-back reads, mdata 1,2,3,4, to preloaded lines -> four consecutive C0RxRdValid cycles, mdata 1,2,3,4 in order, correct data.
- Hold reads without draining until 12 are queued (FIFO_DEPTH=16) -> C0TxAlmFull=1 the cycle after the 12th acceptance; falls after occupancy drops to 11.
- Issue a 17th request with the queue full -> request dropped, err_overflow=1 and stays 1 until resetb pulses low.
- Queue 3 reads, assert resetb=0 mid-flight for 2 cycles -> all outputs 0 immediately; no responses after release; earlier written line reads back unchanged.
- Read and write to addr 0x20 timed to pop in the same cycle (old data 0x0, new data 0xFF) -> read returns 0x0; a subsequent read returns 0xFF.
